hdr_frame_writer: RTL and testbench

Single-clock, parametrised write engine that buffers HDR pixel words in a local FIFO and issues word writes to the SDRAM controller, walking a ring of NUM_BUFS frame buffers. Sits between the HDR merge pipeline (already in the 133 MHz domain) and the RAM arbiter. It adds backpressure, end-of-frame tagging, N-way buffer rotation and address wrap protection.

---
 rtl/hdr_pkg.sv | 23 ++
 rtl/hdr_sync_fifo.sv | 57 +++++
 rtl/hdr_frame_writer.sv | 162 ++++++++++++++++
 tb/tb_hdr_frame_writer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_pkg.sv
// hdr_pkg: shared definitions for the HDR frame write engine.
//   - default data / address widths
//   - write FSM state encoding (IDLE, ISSUE, GAP)
//   - buf_base(): start address of frame buffer idx in the ring
package hdr_pkg;

    localparam int unsigned HDR_DATA_W = 128;
    localparam int unsigned HDR_ADDR_W = 25;

    // Write FSM state encoding
    typedef logic [1:0] hdr_state_t;
    localparam hdr_state_t ST_IDLE  = 2'd0;
    localparam hdr_state_t ST_ISSUE = 2'd1;
    localparam hdr_state_t ST_GAP   = 2'd2;

    // base(i) = base0 + i*stride; the caller truncates to its address width
    function automatic logic [63:0] buf_base(input logic [63:0] base0,
                                             input logic [63:0] stride,
                                             input logic [31:0] idx);
        return base0 + stride * {32'd0, idx};
    endfunction

endpackage

// File: rtl/hdr_sync_fifo.sv
// hdr_sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk_133M, rst_133M : clock, asynchronous active-high reset (discards contents)
//   push, push_data    : write request / word (ignored while full)
//   pop, pop_data      : read request (ignored while empty) / head word
//   full               : registered, occupancy == DEPTH
//   count              : registered occupancy, $clog2(DEPTH)+1 bits
module hdr_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_133M,
    input  logic                     rst_133M,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CW-1:0]    count_nxt;

    assign push_ok   = push & ~full;
    assign pop_ok    = pop & (count != '0);
    assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
    assign pop_data  = mem[rd_ptr];

    // Storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk_133M) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Pointers, occupancy and full flag
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/hdr_frame_writer.sv
// hdr_frame_writer: buffers HDR pixel words and writes them to SDRAM,
// rotating through a ring of NUM_BUFS frame buffers.
// Ports:
//   clk_133M, rst_133M          : clock, asynchronous active-high reset
//   pix_data/pix_last/pix_valid : pixel word, end-of-frame tag, strobe
//   pix_ready                   : FIFO not full (words offered while full are dropped)
//   ram_busy                    : controller stall, sampled only in IDLE
//   wr_req/wr_address/wr_data   : one-cycle write request with address and data
//   frame_done                  : pulses with the wr_req of a tagged word
//   rd_buf_sel                  : most recently completed buffer
//   wrap_err                    : sticky, a frame overran FRAME_WORDS
// Optional macro HDR_WR_STATS_EN adds drop_cnt and frame_words outputs.
module hdr_frame_writer
    import hdr_pkg::*;
#(
    parameter int unsigned       DATA_W      = HDR_DATA_W,
    parameter int unsigned       ADDR_W      = HDR_ADDR_W,
    parameter int unsigned       DEPTH       = 8,
    parameter int unsigned       NUM_BUFS    = 2,
    parameter logic [ADDR_W-1:0] BUF0_BASE   = ADDR_W'(25'hE1000),
    parameter logic [ADDR_W-1:0] BUF_STRIDE  = ADDR_W'(25'h25800),
    parameter int unsigned       ADDR_STEP   = 4,
    parameter int unsigned       FRAME_WORDS = 38400,
    parameter int unsigned       GAP_CYCLES  = 1
) (
    input  logic                 clk_133M,
    input  logic                 rst_133M,
    input  logic [DATA_W-1:0]    pix_data,
    input  logic                 pix_last,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 ram_busy,
    output logic                 wr_req,
    output logic [ADDR_W-1:0]    wr_address,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 frame_done,
    output logic [1:0]           rd_buf_sel,
    output logic                 wrap_err
`ifdef HDR_WR_STATS_EN
    ,
    output logic [15:0]                      drop_cnt,
    output logic [$clog2(FRAME_WORDS):0]     frame_words
`endif
);

    localparam int unsigned WC_W     = $clog2(FRAME_WORDS) + 1;
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

    logic [DATA_W:0]     fifo_rd;
    logic                fifo_full;
    logic [CNT_W-1:0]    fifo_count;
    logic                pop_c;
    hdr_state_t          state;
    hdr_state_t          state_nxt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [WC_W-1:0]     word_cnt;
    logic [1:0]          wr_buf;
    logic [ADDR_W-1:0]   addr_c;

    // Word FIFO; MSB carries the end-of-frame tag
    hdr_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_133M  (clk_133M),
        .rst_133M  (rst_133M),
        .push      (pix_valid),
        .push_data ({pix_last, pix_data}),
        .pop       (pop_c),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign pix_ready = ~fifo_full;

    // Address of the next word: buffer base plus word offset
    assign addr_c = ADDR_W'(buf_base(64'(BUF0_BASE), 64'(BUF_STRIDE), 32'(wr_buf))
                    + 64'(word_cnt) * 64'(ADDR_STEP));

    // State register and gap counter
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_ISSUE)    gap_cnt <= GAP_W'(GAP_LOAD);
            else if (state == ST_GAP) gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // Next state. The IDLE cycle in which the next request is decided is the
    // last of the GAP_CYCLES idle cycles, so GAP itself spans GAP_CYCLES-1
    // cycles and peak rate is one write per 1+GAP_CYCLES cycles.
    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((fifo_count != '0) && !ram_busy) begin
                    state_nxt = ST_ISSUE;
                    pop_c     = 1'b1;
                end
            end
            ST_ISSUE: state_nxt = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Request outputs and buffer bookkeeping, all updated on the pop edge
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            wr_req     <= 1'b0;
            wr_address <= BUF0_BASE;
            wr_data    <= '0;
            frame_done <= 1'b0;
            rd_buf_sel <= 2'(NUM_BUFS - 1);
            wrap_err   <= 1'b0;
            word_cnt   <= '0;
            wr_buf     <= '0;
        end else if (pop_c) begin
            wr_req     <= 1'b1;
            wr_address <= addr_c;
            wr_data    <= fifo_rd[DATA_W-1:0];
            frame_done <= fifo_rd[DATA_W];
            if (fifo_rd[DATA_W]) begin
                word_cnt   <= '0;
                rd_buf_sel <= wr_buf;
                wr_buf     <= (wr_buf == 2'(NUM_BUFS - 1)) ? 2'd0 : wr_buf + 2'd1;
            end else if (word_cnt == WC_W'(FRAME_WORDS - 1)) begin
                // Overrun: stay in this buffer, restart at its base
                word_cnt <= '0;
                wrap_err <= 1'b1;
            end else begin
                word_cnt <= word_cnt + WC_W'(1);
            end
        end else begin
            wr_req     <= 1'b0;
            frame_done <= 1'b0;
        end
    end

`ifdef HDR_WR_STATS_EN
    // Saturating drop counter and word count of the last completed frame
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            drop_cnt    <= '0;
            frame_words <= '0;
        end else begin
            if (pix_valid && fifo_full && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
            if (pop_c && fifo_rd[DATA_W])
                frame_words <= word_cnt + WC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hdr_frame_writer.sv
// Testbench for hdr_frame_writer: directed steps plus a random phase, every
// cycle checked against a queue-based reference model.
module tb_hdr_frame_writer;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned NB     = 2;
    localparam int unsigned FW     = 4;
    localparam int unsigned GAP    = 2;
    localparam int unsigned STEP   = 4;
    localparam longint      BASE   = 64'h0E1000;
    localparam longint      STRIDE = 64'h025800;
    localparam int unsigned WC_W   = $clog2(FW) + 1;

    logic              clk_133M = 1'b0;
    logic              rst_133M;
    logic [DATA_W-1:0] pix_data;
    logic              pix_last;
    logic              pix_valid;
    logic              pix_ready;
    logic              ram_busy;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic [1:0]        rd_buf_sel;
    logic              wrap_err;
`ifdef HDR_WR_STATS_EN
    logic [15:0]       drop_cnt;
    logic [WC_W-1:0]   frame_words;
`endif

    always #5 clk_133M = ~clk_133M;

    hdr_frame_writer #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .NUM_BUFS    (NB),
        .BUF0_BASE   (25'hE1000),
        .BUF_STRIDE  (25'h25800),
        .ADDR_STEP   (STEP),
        .FRAME_WORDS (FW),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk_133M   (clk_133M),
        .rst_133M   (rst_133M),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .ram_busy   (ram_busy),
        .wr_req     (wr_req),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .rd_buf_sel (rd_buf_sel),
        .wrap_err   (wrap_err)
`ifdef HDR_WR_STATS_EN
        ,
        .drop_cnt    (drop_cnt),
        .frame_words (frame_words)
`endif
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } word_t;

    // Reference model state
    word_t             q[$];
    logic [ADDR_W-1:0] iss_addr[$];
    int                cool;
    int                m_buf;
    int                m_cnt;
    int                m_rd_sel;
    bit                m_wrap;
    bit                e_req;
    bit                e_done;
    bit                e_ready;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    int                e_drop;
    int                e_fwords;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cool     = 0;
        m_buf    = 0;
        m_cnt    = 0;
        m_rd_sel = NB - 1;
        m_wrap   = 1'b0;
        e_req    = 1'b0;
        e_done   = 1'b0;
        e_ready  = 1'b1;
        e_addr   = ADDR_W'(BASE);
        e_data   = '0;
        e_drop   = 0;
        e_fwords = 0;
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ".wr_req"},     128'(wr_req),     128'(e_req));
        chk({ph, ".frame_done"}, 128'(frame_done), 128'(e_done));
        chk({ph, ".pix_ready"},  128'(pix_ready),  128'(e_ready));
        chk({ph, ".wrap_err"},   128'(wrap_err),   128'(m_wrap));
        chk({ph, ".rd_buf_sel"}, 128'(rd_buf_sel), 128'(m_rd_sel));
        chk({ph, ".wr_address"}, 128'(wr_address), 128'(e_addr));
        chk({ph, ".wr_data"},    128'(wr_data),    128'(e_data));
`ifdef HDR_WR_STATS_EN
        chk({ph, ".drop_cnt"},    128'(drop_cnt),    128'(e_drop));
        chk({ph, ".frame_words"}, 128'(frame_words), 128'(e_fwords));
`endif
    endtask

    // One clock: advance the model with the inputs present at the edge, then check
    task automatic step(input string ph);
        bit    push_ok;
        bit    pop;
        word_t w;
        longint a;
        @(posedge clk_133M);
        push_ok = pix_valid && (q.size() < DEPTH);
        pop     = (q.size() > 0) && !ram_busy && (cool == 0);
        if (pix_valid && !push_ok && e_drop < 65535) e_drop++;
        if (cool > 0) cool--;
        e_req  = pop;
        e_done = 1'b0;
        if (pop) begin
            w      = q.pop_front();
            a      = BASE + longint'(m_buf) * STRIDE + longint'(m_cnt) * STEP;
            e_addr = ADDR_W'(a);
            e_data = w.d;
            cool   = GAP;
            iss_addr.push_back(e_addr);
            if (w.l) begin
                e_done   = 1'b1;
                e_fwords = m_cnt + 1;
                m_rd_sel = m_buf;
                m_buf    = (m_buf + 1) % NB;
                m_cnt    = 0;
            end else begin
                m_cnt++;
                if (m_cnt == FW) begin
                    m_cnt  = 0;
                    m_wrap = 1'b1;
                end
            end
        end
        if (push_ok) begin
            w.d = pix_data;
            w.l = pix_last;
            q.push_back(w);
        end
        e_ready = (q.size() < DEPTH);
        #1;
        check_outputs(ph);
    endtask

    task automatic run(input string ph, input int n);
        for (int i = 0; i < n; i++) step(ph);
    endtask

    task automatic drive_word(input logic last);
        pix_valid = 1'b1;
        pix_last  = last;
        pix_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    // Push n words back-to-back, the last of them tagged if last_tag
    task automatic push_frame(input string ph, input int n, input bit last_tag);
        for (int i = 0; i < n; i++) begin
            drive_word(last_tag && (i == n - 1));
            step(ph);
        end
        idle_inputs();
    endtask

    initial begin
        rst_133M  = 1'b1;
        pix_data  = '0;
        pix_last  = 1'b0;
        pix_valid = 1'b0;
        ram_busy  = 1'b0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk_133M);
        #1;
        check_outputs("reset");
        chk("reset.addr_const", 128'(wr_address), 128'(25'hE1000));
        chk("reset.rd_sel_const", 128'(rd_buf_sel), 128'(2'd1));
        #2 rst_133M = 1'b0;
        run("post_reset", 2);

        // Frame 1: three words, first request two edges after the push
        iss_addr.delete();
        drive_word(1'b0);
        step("f1");
        drive_word(1'b0);
        step("f1");
        chk("f1.first_latency", 128'(wr_req), 128'(1'b1));
        drive_word(1'b1);
        step("f1");
        idle_inputs();
        run("f1", 8);
        chk("f1.addr0", 128'(iss_addr[0]), 128'(25'hE1000));
        chk("f1.addr1", 128'(iss_addr[1]), 128'(25'hE1004));
        chk("f1.addr2", 128'(iss_addr[2]), 128'(25'hE1008));
        chk("f1.rd_sel", 128'(rd_buf_sel), 128'(2'd0));

        // Frame 2 lands in buffer 1, frame 3 back in buffer 0
        iss_addr.delete();
        push_frame("f2", 3, 1'b1);
        run("f2", 8);
        chk("f2.addr0", 128'(iss_addr[0]), 128'(25'h106800));
        chk("f2.addr2", 128'(iss_addr[2]), 128'(25'h106808));
        chk("f2.rd_sel", 128'(rd_buf_sel), 128'(2'd1));
        iss_addr.delete();
        push_frame("f3", 3, 1'b1);
        run("f3", 8);
        chk("f3.addr0", 128'(iss_addr[0]), 128'(25'hE1000));

        // Overflow: 12 words while busy, 8 accepted (two 4-word frames), 4 dropped
        ram_busy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_word(i == 3 || i == 7);
            step("drop");
            if (i == 7) chk("drop.ready_low", 128'(pix_ready), 128'(1'b0));
        end
        idle_inputs();
        step("drop");
`ifdef HDR_WR_STATS_EN
        chk("drop.cnt", 128'(drop_cnt), 128'(16'd4));
`endif
        iss_addr.delete();
        ram_busy = 1'b0;
        run("drain", 30);
        chk("drain.writes", 128'(iss_addr.size()), 128'(8));
        chk("drain.ready", 128'(pix_ready), 128'(1'b1));

        // ram_busy during ISSUE/GAP is ignored; in IDLE it holds the request
        drive_word(1'b0);
        step("busy");
        drive_word(1'b0);
        step("busy");
        ram_busy = 1'b1;
        drive_word(1'b1);
        step("busy");
        idle_inputs();
        step("busy");
        ram_busy = 1'b0;
        step("busy");
        chk("busy.gap_ignored", 128'(wr_req), 128'(1'b1));
        ram_busy = 1'b1;
        run("busy", 4);
        chk("busy.held", 128'(wr_req), 128'(1'b0));
        ram_busy = 1'b0;
        step("busy");
        chk("busy.release", 128'(wr_req), 128'(1'b1));
        run("busy", 6);

        // Overrun: five untagged words into a 4-word buffer, then close
        iss_addr.delete();
        push_frame("wrap", 5, 1'b0);
        push_frame("wrap", 1, 1'b1);
        run("wrap", 20);
        chk("wrap.fifth_addr", 128'(iss_addr[4]), 128'(iss_addr[0]));
        chk("wrap.err", 128'(wrap_err), 128'(1'b1));

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 60) drive_word($urandom_range(99) < 20);
            else idle_inputs();
            ram_busy = ($urandom_range(99) < 30);
            step("rand");
        end
        idle_inputs();
        ram_busy = 1'b0;
        run("rand_drain", 40);

        // Leave wr_buf at 1 so the reset's effect on it is visible
        if (m_buf == 0) begin
            push_frame("pre_rst", 1, 1'b1);
            run("pre_rst", 6);
        end

        // Reset while a request is in flight
        drive_word(1'b0);
        step("rst_mid");
        drive_word(1'b0);
        step("rst_mid");
        idle_inputs();
        chk("rst_mid.in_issue", 128'(wr_req), 128'(1'b1));
        #2 rst_133M = 1'b1;
        #1;
        chk("rst_mid.req_drop", 128'(wr_req), 128'(1'b0));
        chk("rst_mid.addr", 128'(wr_address), 128'(25'hE1000));
        chk("rst_mid.ready", 128'(pix_ready), 128'(1'b1));
        chk("rst_mid.wrap", 128'(wrap_err), 128'(1'b0));
        #2 rst_133M = 1'b0;
        model_reset();
        run("rst_empty", 6);
        iss_addr.delete();
        push_frame("rst_after", 1, 1'b1);
        run("rst_after", 4);
        chk("rst_after.count", 128'(iss_addr.size()), 128'(1));
        chk("rst_after.buf0", 128'(iss_addr[0]), 128'(25'hE1000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
